// File: rtl/bus_bridge_pkg.sv
// Shared bus-bridge types and UART framing constants for the target end of the link.
package bus_bridge_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  write_data;
        logic        is_write;
    } bus_bridge_req_t;

    typedef struct packed {
        logic [7:0] read_data;
        logic       is_write;
    } bus_bridge_resp_t;

    localparam int BB_UART_REQ_BYTES      = 4;
    localparam int BB_UART_RESP_BYTES     = 2;
    localparam int BB_UART_FLAG_WRITE_BIT = 0;

    typedef enum logic [2:0] {
        BB_T_IDLE,
        BB_T_TX_SEND,
        BB_T_TX_WAIT,
        BB_T_RX_WAIT,
        BB_T_RESP_HOLD
    } bb_target_state_e;

    // Request frame byte order on the wire: addr low, addr high, data, flags.
    function automatic logic [7:0] bb_req_byte(input bus_bridge_req_t req, input logic [1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            2'd0:    b = req.addr[7:0];
            2'd1:    b = req.addr[15:8];
            2'd2:    b = req.write_data;
            default: b[BB_UART_FLAG_WRITE_BIT] = req.is_write;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bus_bridge_timeout_counter.sv
// Saturating cycle counter that flags expiry at LIMIT; LIMIT of 0 never expires.
module bus_bridge_timeout_counter #(
    parameter logic [31:0] LIMIT = 32'd5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear)                        count_d = '0;
        else if (enable && count_q < LIMIT) count_d = count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign expired = (LIMIT != 32'd0) && (count_q >= LIMIT);

endmodule

// File: rtl/uart.sv
// 8N1 UART with a single-byte TX holding register and an RX ready flag.
// No reset: state powers up idle; 'clear' is a synchronous flush.
module uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_50m,
    input  logic       clear,
    input  logic       wr_en,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
    output logic       ready,
    input  logic       ready_clr,
    output logic [7:0] data_out
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);

    logic          tx_busy_q, tx_busy_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [9:0]    tx_shift_q, tx_shift_d;

    logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
    logic          rx_active_q, rx_active_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          ready_q, ready_d;
    logic [7:0]    data_q, data_d;

    always_comb begin
        tx_busy_d  = tx_busy_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        if (!tx_busy_q) begin
            if (wr_en) begin
                tx_busy_d  = 1'b1;
                tx_shift_d = {1'b1, data_in, 1'b0};
                tx_cnt_d   = '0;
                tx_bit_d   = 4'd0;
            end
        end else if (tx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
            tx_cnt_d   = '0;
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
            else                  tx_bit_d  = tx_bit_q + 4'd1;
        end else begin
            tx_cnt_d = tx_cnt_q + CW'(1);
        end

        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        rx_prev_d   = rx_sync_q;
        rx_active_d = rx_active_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        data_d      = data_q;
        ready_d     = ready_clr ? 1'b0 : ready_q;
        if (!rx_active_q) begin
            if (rx_prev_q && !rx_sync_q) begin
                rx_active_d = 1'b1;
                rx_cnt_d    = '0;
                rx_bit_d    = 4'd0;
            end
        end else begin
            // Sample mid-bit; a start bit that is high again by then is a glitch.
            if (rx_cnt_q == CW'(CLKS_PER_BIT / 2)) begin
                if (rx_bit_q == 4'd0) begin
                    if (rx_sync_q) rx_active_d = 1'b0;
                end else if (rx_bit_q == 4'd9) begin
                    rx_active_d = 1'b0;
                    if (rx_sync_q) begin
                        ready_d = 1'b1;
                        data_d  = rx_shift_q;
                    end
                end else begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                end
            end
            if (rx_cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                rx_cnt_d = '0;
                rx_bit_d = rx_bit_q + 4'd1;
            end else begin
                rx_cnt_d = rx_cnt_q + CW'(1);
            end
        end

        if (clear) begin
            tx_busy_d   = 1'b0;
            rx_active_d = 1'b0;
            ready_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_50m) begin
        tx_busy_q   <= tx_busy_d;
        tx_cnt_q    <= tx_cnt_d;
        tx_bit_q    <= tx_bit_d;
        tx_shift_q  <= tx_shift_d;
        rx_meta_q   <= rx_meta_d;
        rx_sync_q   <= rx_sync_d;
        rx_prev_q   <= rx_prev_d;
        rx_active_q <= rx_active_d;
        rx_cnt_q    <= rx_cnt_d;
        rx_bit_q    <= rx_bit_d;
        rx_shift_q  <= rx_shift_d;
        ready_q     <= ready_d;
        data_q      <= data_d;
    end

    assign tx       = tx_busy_q ? tx_shift_q[0] : 1'b1;
    assign tx_busy  = tx_busy_q;
    assign ready    = ready_q;
    assign data_out = data_q;

endmodule

// File: rtl/bus_bridge_target_uart_wrapper.sv
// Target end of the bus-bridge UART link: sends a 4-byte request frame and
// collects the 2-byte response frame, with a timeout so a dead link cannot hang the bus.
module bus_bridge_target_uart_wrapper
    import bus_bridge_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES    = 32'd5_000_000,
    parameter int          UART_CLKS_PER_BIT = 434
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  bus_bridge_req_t  req_payload,
    output logic             resp_valid,
    input  logic             resp_ready,
    output bus_bridge_resp_t resp_payload,
    output logic             uart_tx,
    input  logic             uart_rx,
    output logic             busy,
    output logic             resp_timeout,
    output logic             stray_byte
);
    bb_target_state_e state_q, state_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    bus_bridge_req_t  req_pending_q, req_pending_d;
    bus_bridge_resp_t resp_payload_q, resp_payload_d;
    logic [7:0]       read_data_q, read_data_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_timeout_q, resp_timeout_d;
    logic             stray_byte_q, stray_byte_d;
    logic             uart_wr_en_q, uart_wr_en_d;
    logic             uart_ready_clr_q, uart_ready_clr_d;
    logic [7:0]       uart_data_in_q, uart_data_in_d;
    logic             tx_busy_prev_q;

    logic       uart_tx_busy, uart_ready;
    logic [7:0] uart_data_out;
    logic       to_clear, to_expired, tx_done, rx_byte;

    assign tx_done = tx_busy_prev_q && !uart_tx_busy;
    // ready stays high for one more cycle while our clear is in flight.
    assign rx_byte = uart_ready && !uart_ready_clr_q;

    always_comb begin
        state_d          = state_q;
        byte_idx_d       = byte_idx_q;
        req_pending_d    = req_pending_q;
        resp_payload_d   = resp_payload_q;
        read_data_d      = read_data_q;
        resp_valid_d     = resp_valid_q;
        resp_timeout_d   = 1'b0;
        stray_byte_d     = 1'b0;
        uart_wr_en_d     = 1'b0;
        uart_ready_clr_d = 1'b0;
        uart_data_in_d   = uart_data_in_q;
        to_clear         = 1'b0;

        case (state_q)
            BB_T_IDLE: begin
                if (req_valid) begin
                    req_pending_d = req_payload;
                    byte_idx_d    = 2'd0;
                    state_d       = BB_T_TX_SEND;
                end
            end
            BB_T_TX_SEND: begin
                if (!uart_tx_busy) begin
                    uart_data_in_d = bb_req_byte(req_pending_q, byte_idx_q);
                    uart_wr_en_d   = 1'b1;
                    state_d        = BB_T_TX_WAIT;
                end
            end
            BB_T_TX_WAIT: begin
                if (tx_done) begin
                    if (byte_idx_q == 2'(BB_UART_REQ_BYTES - 1)) begin
                        to_clear   = 1'b1;
                        byte_idx_d = 2'd0;
                        state_d    = BB_T_RX_WAIT;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = BB_T_TX_SEND;
                    end
                end
            end
            BB_T_RX_WAIT: begin
                // A byte landing on the expiry cycle takes precedence over the timeout.
                if (rx_byte) begin
                    uart_ready_clr_d = 1'b1;
                    if (byte_idx_q == 2'(BB_UART_RESP_BYTES - 1)) begin
                        resp_payload_d.read_data = read_data_q;
                        resp_payload_d.is_write  = uart_data_out[BB_UART_FLAG_WRITE_BIT];
                        resp_valid_d             = 1'b1;
                        state_d                  = BB_T_RESP_HOLD;
                    end else begin
                        read_data_d = uart_data_out;
                        byte_idx_d  = byte_idx_q + 2'd1;
                    end
                end else if (to_expired) begin
                    resp_payload_d = '{read_data: 8'h00, is_write: req_pending_q.is_write};
                    resp_valid_d   = 1'b1;
                    resp_timeout_d = 1'b1;
                    byte_idx_d     = 2'd0;
                    state_d        = BB_T_RESP_HOLD;
                end
            end
            BB_T_RESP_HOLD: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = BB_T_IDLE;
                end
            end
            default: state_d = BB_T_IDLE;
        endcase

        if (rx_byte && state_q != BB_T_RX_WAIT) begin
            uart_ready_clr_d = 1'b1;
            stray_byte_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= BB_T_IDLE;
            byte_idx_q       <= 2'd0;
            req_pending_q    <= '0;
            resp_payload_q   <= '0;
            read_data_q      <= 8'h00;
            resp_valid_q     <= 1'b0;
            resp_timeout_q   <= 1'b0;
            stray_byte_q     <= 1'b0;
            uart_wr_en_q     <= 1'b0;
            uart_ready_clr_q <= 1'b0;
            uart_data_in_q   <= 8'h00;
            tx_busy_prev_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            byte_idx_q       <= byte_idx_d;
            req_pending_q    <= req_pending_d;
            resp_payload_q   <= resp_payload_d;
            read_data_q      <= read_data_d;
            resp_valid_q     <= resp_valid_d;
            resp_timeout_q   <= resp_timeout_d;
            stray_byte_q     <= stray_byte_d;
            uart_wr_en_q     <= uart_wr_en_d;
            uart_ready_clr_q <= uart_ready_clr_d;
            uart_data_in_q   <= uart_data_in_d;
            tx_busy_prev_q   <= uart_tx_busy;
        end
    end

    bus_bridge_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (to_clear),
        .enable  (state_q == BB_T_RX_WAIT),
        .expired (to_expired)
    );

    uart #(
        .CLKS_PER_BIT (UART_CLKS_PER_BIT)
    ) u_uart (
        .clk_50m   (clk),
        .clear     (1'b0),
        .wr_en     (uart_wr_en_q),
        .data_in   (uart_data_in_q),
        .tx        (uart_tx),
        .tx_busy   (uart_tx_busy),
        .rx        (uart_rx),
        .ready     (uart_ready),
        .ready_clr (uart_ready_clr_q),
        .data_out  (uart_data_out)
    );

    assign req_ready    = (state_q == BB_T_IDLE);
    assign busy         = (state_q != BB_T_IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_payload = resp_payload_q;
    assign resp_timeout = resp_timeout_q;
    assign stray_byte   = stray_byte_q;

endmodule

// File: tb/tb_bus_bridge_target_uart_wrapper.sv
// Directed and randomized bench for the target-side UART wrapper with a serial line model.
`timescale 1ns/1ps
module tb_bus_bridge_target_uart_wrapper;
    import bus_bridge_pkg::*;

    localparam int          CPB = 16;
    localparam logic [31:0] TO  = 32'd20000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             resp_ready = 1'b0;
    logic             uart_rx = 1'b1;
    bus_bridge_req_t  req_payload = '0;
    logic             req_ready, resp_valid, uart_tx, busy, resp_timeout, stray_byte;
    bus_bridge_resp_t resp_payload;

    int total = 0;
    int bad = 0;
    int accepts = 0;
    int to_pulses = 0;
    int stray_pulses = 0;
    logic [7:0] tx_q[$];

    always #10 clk = ~clk;

    bus_bridge_target_uart_wrapper #(
        .TIMEOUT_CYCLES    (TO),
        .UART_CLKS_PER_BIT (CPB)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_payload  (req_payload),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_payload (resp_payload),
        .uart_tx      (uart_tx),
        .uart_rx      (uart_rx),
        .busy         (busy),
        .resp_timeout (resp_timeout),
        .stray_byte   (stray_byte)
    );

    always @(posedge clk) begin
        if (req_valid && req_ready) accepts <= accepts + 1;
        if (resp_timeout)           to_pulses <= to_pulses + 1;
        if (stray_byte)             stray_pulses <= stray_pulses + 1;
    end

    // Far-end receiver: decodes 8N1 bytes from uart_tx into tx_q.
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            repeat (CPB / 2) @(posedge clk);
            if (uart_tx == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    b[i] = uart_tx;
                end
                repeat (CPB) @(posedge clk);
                if (uart_tx) tx_q.push_back(b);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input bus_bridge_req_t r, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        req_payload = r;
        req_valid   = 1'b1;
        while (!req_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic check_frame(input bus_bridge_req_t r, input string tag);
        logic [7:0] exp [4];
        logic [7:0] got;
        int n;
        n = 0;
        exp[0] = r.addr[7:0];
        exp[1] = r.addr[15:8];
        exp[2] = r.write_data;
        exp[3] = {7'b0, r.is_write};
        while (tx_q.size() < 4 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_nbytes"}, 32'(tx_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (tx_q.size() > 0) got = tx_q.pop_front();
            else                 got = 8'hxx;
            chk($sformatf("%s_txbyte%0d", tag, i), 32'(got), 32'(exp[i]));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic expect_resp(input bus_bridge_resp_t exp, input int hold, input int max_wait,
                               input string tag, output int waited);
        int stable;
        waited = 0;
        stable = 0;
        while (!resp_valid && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_payload"}, 32'(resp_payload), 32'(exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (resp_valid && resp_payload === exp && !req_ready && busy) stable++;
        end
        chk({tag, "_hold"}, 32'(stable), 32'(hold));
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_vfall"}, 32'(resp_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Reference: response is {rx byte 0, bit 0 of rx byte 1}.
    task automatic respond_and_check(input bus_bridge_req_t r, input logic [7:0] b0,
                                     input logic [7:0] b1, input int hold, input string tag);
        bus_bridge_resp_t e;
        int w;
        check_frame(r, tag);
        send_byte(b0);
        send_byte(b1);
        e.read_data = b0;
        e.is_write  = b1[0];
        expect_resp(e, hold, 2000, tag, w);
    endtask

    task automatic run_txn(input bus_bridge_req_t r, input logic [7:0] b0,
                           input logic [7:0] b1, input int hold, input string tag);
        send_req(r, tag);
        respond_and_check(r, b0, b1, hold, tag);
    endtask

    initial begin : main
        bus_bridge_req_t  r, r2;
        bus_bridge_resp_t e;
        int lat, acc0, st0, to0, rv;
        logic [7:0] got;

        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_payload", 32'(resp_payload), 32'd0);
        chk("rst_flags", {30'd0, resp_timeout, stray_byte}, 32'd0);
        chk("rst_tx_idle", 32'(uart_tx), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        r = '{addr: 16'h12A4, write_data: 8'h5C, is_write: 1'b1};
        run_txn(r, 8'h00, 8'h01, 0, "wr");

        r = '{addr: 16'hBEEF, write_data: 8'h00, is_write: 1'b0};
        run_txn(r, 8'h3C, 8'h00, 50, "rd");

        to0 = to_pulses;
        r = '{addr: 16'h4321, write_data: 8'h00, is_write: 1'b0};
        send_req(r, "to");
        check_frame(r, "to");
        send_byte(8'h77);
        e = '{read_data: 8'h00, is_write: 1'b0};
        expect_resp(e, 3, 25000, "to", lat);
        lat = lat + (10 * CPB) + 1;
        chk("to_latency", 32'(lat >= int'(TO) && lat <= int'(TO) + 60), 32'd1);
        chk("to_pulses", 32'(to_pulses - to0), 32'd1);
        chk("to_back_idle", 32'(req_ready), 32'd1);

        st0 = stray_pulses;
        send_byte(8'hAA);
        rv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) rv++;
        end
        chk("stray_pulse", 32'(stray_pulses - st0), 32'd1);
        chk("stray_no_resp", 32'(rv), 32'd0);
        r = '{addr: 16'(($urandom)), write_data: 8'($urandom), is_write: 1'b1};
        run_txn(r, 8'($urandom), 8'h81, 0, "post_stray");
        chk("stray_once", 32'(stray_pulses - st0), 32'd1);

        r  = '{addr: 16'hA55A, write_data: 8'h11, is_write: 1'b1};
        r2 = '{addr: 16'h0102, write_data: 8'h22, is_write: 1'b0};
        send_req(r, "b2b1");
        req_payload = r2;
        req_valid   = 1'b1;
        acc0 = accepts;
        respond_and_check(r, 8'h9A, 8'h01, 5, "b2b1");
        chk("b2b_not_yet", 32'(accepts - acc0), 32'd0);
        chk("b2b_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("b2b_accepted", 32'(accepts - acc0), 32'd1);
        req_valid = 1'b0;
        respond_and_check(r2, 8'h5E, 8'hFE, 0, "b2b2");

        r = '{addr: 16'h0F0F, write_data: 8'h99, is_write: 1'b1};
        send_req(r, "mid");
        lat = 0;
        while (tx_q.size() < 2 && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        repeat (CPB * 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_resp", {22'd0, resp_valid, resp_payload}, 32'd0);
        chk("mid_rst_flags", {30'd0, resp_timeout, stray_byte}, 32'd0);
        repeat (CPB * 12) @(negedge clk);
        chk("mid_rst_nbytes", 32'(tx_q.size()), 32'd3);
        got = (tx_q.size() == 3) ? tx_q[2] : 8'hxx;
        chk("mid_rst_byte2", 32'(got), 32'h99);
        tx_q.delete();
        r = '{addr: 16'hC0DE, write_data: 8'h42, is_write: 1'b0};
        run_txn(r, 8'hE7, 8'h00, 2, "after_rst");

        for (int k = 0; k < 4; k++) begin
            r = '{addr: 16'($urandom), write_data: 8'($urandom), is_write: 1'($urandom)};
            run_txn(r, 8'($urandom), 8'($urandom), int'($urandom_range(0, 6)), $sformatf("rnd%0d", k));
        end
        chk("no_spurious_timeout", 32'(to_pulses - to0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
